// File: rtl/wb_stage_pkg.sv
// Shared constants and the held-instruction record for the write-back stage.
package wb_stage_pkg;

  // Bit positions within the one-hot align_load vector
  localparam int LD_LW  = 6;
  localparam int LD_LB  = 5;
  localparam int LD_LBU = 4;
  localparam int LD_LH  = 3;
  localparam int LD_LHU = 2;
  localparam int LD_LWL = 1;
  localparam int LD_LWR = 0;

  // Bit positions within the one-hot rf_wdata_src vector
  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;
  localparam int SRC_PC8 = 2;

  // Stage occupancy states
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  // Everything latched from the memory-access stage on a handshake
  typedef struct packed {
    logic [31:0] rf_b;
    logic [4:0]  waddr;
    logic [2:0]  src;
    logic        wen;
    logic [31:0] alu_res;
    logic        mem_read;
    logic [6:0]  align_load;
    logic [31:0] pc;
  } wb_fields_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load aligner: extracts/extends bytes and halfwords and
// performs the lwl/lwr merge with the old rt value.
module load_align
  import wb_stage_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [31:0] rf_b,
  input  logic [1:0]  addr,
  input  logic [6:0]  align_load,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = mem_rdata[{addr, 3'b000} +: 8];
  assign half_v = mem_rdata[{addr[1], 4'b0000} +: 16];

  // Select the aligned value by load type; no type selected yields zero
  always_comb begin
    result = '0;
    if (align_load[LD_LW])
      result = mem_rdata;
    else if (align_load[LD_LB])
      result = {{24{byte_v[7]}}, byte_v};
    else if (align_load[LD_LBU])
      result = {24'h0, byte_v};
    else if (align_load[LD_LH])
      result = {{16{half_v[15]}}, half_v};
    else if (align_load[LD_LHU])
      result = {16'h0, half_v};
    else if (align_load[LD_LWL]) begin
      case (addr)
        2'd0:    result = {mem_rdata[7:0],  rf_b[23:0]};
        2'd1:    result = {mem_rdata[15:0], rf_b[15:0]};
        2'd2:    result = {mem_rdata[23:0], rf_b[7:0]};
        default: result = mem_rdata;
      endcase
    end else if (align_load[LD_LWR]) begin
      case (addr)
        2'd0:    result = mem_rdata;
        2'd1:    result = {rf_b[31:24], mem_rdata[31:8]};
        2'd2:    result = {rf_b[31:16], mem_rdata[31:16]};
        default: result = {rf_b[31:8],  mem_rdata[31:24]};
      endcase
    end
  end

endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: holds one instruction, waits for load data when
// needed, and drives the register-file write port for one cycle.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_p,
  input  logic        MA_ready,
  output logic        WB_enable,
  input  logic        mem_rdata_valid,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] rf_B_in,
  input  logic [4:0]  rf_waddr_in,
  input  logic [2:0]  rf_wdata_src_in,
  input  logic        rf_wen_in,
  input  logic [31:0] alu_res_in,
  input  logic        mem_read_in,
  input  logic [6:0]  align_load_in,
  input  logic [31:0] MA_PC,
  output logic [3:0]  rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] WB_PC,
  output logic        valid_out,
  output logic        protocol_err
);

  logic [0:0]  state;
  wb_fields_t  f;
  logic        valid, leaving, comming, stray;
  logic [31:0] ld_data, pc8;

  assign valid   = (state == S_HOLD);
  // Leaving only waits on read data; MA_ready stays out of WB_enable
  assign leaving = valid && !(f.mem_read && !mem_rdata_valid);
  assign WB_enable = !valid || leaving;
  assign comming   = WB_enable && MA_ready;
  assign stray     = mem_rdata_valid && !(valid && f.mem_read);

  load_align u_align (
    .mem_rdata  (mem_rdata),
    .rf_b       (f.rf_b),
    .addr       (f.alu_res[1:0]),
    .align_load (f.align_load),
    .result     (ld_data)
  );

  assign pc8 = f.pc + 32'd8;

  assign rf_wdata = ({32{f.src[SRC_ALU]}} & f.alu_res)
                  | ({32{f.src[SRC_MEM]}} & ld_data)
                  | ({32{f.src[SRC_PC8]}} & pc8);
  // Full-word strobes only; lwl/lwr merging already happened in the data
  assign rf_wen    = {4{valid && f.wen && leaving}};
  assign rf_waddr  = f.waddr;
  assign WB_PC     = f.pc;
  assign valid_out = valid;

  // Occupancy, field capture and sticky error flag; reset drops any held load
  always_ff @(posedge clk) begin
    if (rst_p) begin
      state        <= S_IDLE;
      f            <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (stray) protocol_err <= 1'b1;
      if (comming) begin
        state        <= S_HOLD;
        f.rf_b       <= rf_B_in;
        f.waddr      <= rf_waddr_in;
        f.src        <= rf_wdata_src_in;
        f.wen        <= rf_wen_in;
        f.alu_res    <= alu_res_in;
        f.mem_read   <= mem_read_in;
        f.align_load <= align_load_in;
        f.pc         <= MA_PC;
      end else if (leaving) begin
        state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a cycle model checks every output each cycle,
// and literal expectations from hand calculation pin the model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_p;
  logic        MA_ready;
  logic        WB_enable;
  logic        mem_rdata_valid;
  logic [31:0] mem_rdata;
  logic [31:0] rf_B_in;
  logic [4:0]  rf_waddr_in;
  logic [2:0]  rf_wdata_src_in;
  logic        rf_wen_in;
  logic [31:0] alu_res_in;
  logic        mem_read_in;
  logic [6:0]  align_load_in;
  logic [31:0] MA_PC;
  logic [3:0]  rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] WB_PC;
  logic        valid_out;
  logic        protocol_err;

  int total = 0;
  int bad   = 0;

  wb_stage dut (
    .clk(clk), .rst_p(rst_p), .MA_ready(MA_ready), .WB_enable(WB_enable),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata), .rf_B_in(rf_B_in),
    .rf_waddr_in(rf_waddr_in), .rf_wdata_src_in(rf_wdata_src_in), .rf_wen_in(rf_wen_in),
    .alu_res_in(alu_res_in), .mem_read_in(mem_read_in), .align_load_in(align_load_in),
    .MA_PC(MA_PC), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .WB_PC(WB_PC), .valid_out(valid_out), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] rt;
    logic [4:0]  waddr;
    logic [2:0]  src;
    logic        wen;
    logic [31:0] alu;
    logic        mread;
    logic [6:0]  ld;
    logic [31:0] pc;
  } ins_t;

  ins_t m_ins;
  logic m_valid, m_err;
  bit   started = 0;

  // Load result from byte-lane arithmetic
  function automatic logic [31:0] m_load(input logic [6:0] t, input logic [31:0] d,
                                         input logic [31:0] rt, input logic [1:0] a);
    int sa;
    logic [31:0] b, h;
    sa = int'(a);
    b = (d >> (8 * sa)) & 32'hFF;
    h = (d >> (16 * int'(a[1]))) & 32'hFFFF;
    case (t)
      7'b1000000: return d;
      7'b0100000: return b[7] ? (b | 32'hFFFF_FF00) : b;
      7'b0010000: return b;
      7'b0001000: return h[15] ? (h | 32'hFFFF_0000) : h;
      7'b0000100: return h;
      7'b0000010: return (d << (8 * (3 - sa))) | (rt & ((32'h1 << (8 * (3 - sa))) - 32'h1));
      7'b0000001: return (d >> (8 * sa)) | (rt & ~(32'hFFFF_FFFF >> (8 * sa)));
      default:    return 32'h0;
    endcase
  endfunction

  // Compare every cycle, then advance the model with the inputs for this edge
  always @(negedge clk) begin
    logic        m_leave, e_en;
    logic [3:0]  e_wen;
    logic [31:0] e_data;
    m_leave = m_valid && (!m_ins.mread || mem_rdata_valid);
    e_en    = !m_valid || m_leave;
    e_wen   = (m_leave && m_ins.wen) ? 4'hF : 4'h0;
    e_data  = 32'h0;
    if (m_ins.src == 3'b001) e_data = m_ins.alu;
    if (m_ins.src == 3'b010) e_data = m_load(m_ins.ld, mem_rdata, m_ins.rt, m_ins.alu[1:0]);
    if (m_ins.src == 3'b100) e_data = m_ins.pc + 32'd8;
    if (started) begin
      chk("m_WB_enable", WB_enable, e_en);
      chk("m_valid_out", valid_out, m_valid);
      chk("m_rf_wen", rf_wen, e_wen);
      chk("m_WB_PC", WB_PC, m_ins.pc);
      chk("m_protocol_err", protocol_err, m_err);
      if (e_wen != 4'h0) begin
        chk("m_rf_waddr", rf_waddr, m_ins.waddr);
        chk("m_rf_wdata", rf_wdata, e_data);
      end
    end
    if (rst_p) begin
      m_valid = 0; m_ins = '0; m_err = 0; started = 1;
    end else begin
      if (mem_rdata_valid && !(m_valid && m_ins.mread)) m_err = 1;
      if (e_en && MA_ready) begin
        m_ins = '{rf_B_in, rf_waddr_in, rf_wdata_src_in, rf_wen_in, alu_res_in,
                  mem_read_in, align_load_in, MA_PC};
        m_valid = 1;
      end else if (m_leave) begin
        m_valid = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    MA_ready = 0; mem_rdata_valid = 0; mem_rdata = 0; rf_B_in = 0; rf_waddr_in = 0;
    rf_wdata_src_in = 0; rf_wen_in = 0; alu_res_in = 0; mem_read_in = 0;
    align_load_in = 0; MA_PC = 0;
  endtask

  task automatic drive(input logic [4:0] wa, input logic [2:0] src, input logic [31:0] alu,
                       input logic mr, input logic [6:0] ld, input logic [31:0] pc,
                       input logic [31:0] rt);
    MA_ready = 1; rf_waddr_in = wa; rf_wdata_src_in = src; rf_wen_in = 1;
    alu_res_in = alu; mem_read_in = mr; align_load_in = ld; MA_PC = pc; rf_B_in = rt;
  endtask

  task automatic load_test(input string name, input logic [6:0] ld, input logic [31:0] addr,
                           input logic [31:0] rt, input logic [31:0] d, input int delay,
                           input logic [31:0] exp);
    drive(5'd9, 3'b010, addr, 1'b1, ld, 32'h0000_0200, rt);
    step();
    idle();
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk({name, "_stall_en"}, WB_enable, 1'b0);
      chk({name, "_stall_wen"}, rf_wen, 4'h0);
      step();
    end
    mem_rdata_valid = 1; mem_rdata = d;
    @(negedge clk);
    chk({name, "_wen"}, rf_wen, 4'hF);
    chk({name, "_wdata"}, rf_wdata, exp);
    step();
    idle();
  endtask

  initial begin
    idle();
    rst_p = 1;
    step();
    @(negedge clk);
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_WB_enable", WB_enable, 1'b1);
    chk("rst_rf_wen", rf_wen, 4'h0);
    chk("rst_rf_waddr", rf_waddr, 5'd0);
    chk("rst_rf_wdata", rf_wdata, 32'h0);
    chk("rst_WB_PC", WB_PC, 32'h0);
    chk("rst_protocol_err", protocol_err, 1'b0);
    step();
    rst_p = 0;

    // back-to-back ALU writes
    drive(5'd5, 3'b001, 32'h1234, 1'b0, 7'b0, 32'h100, 32'h0);
    step();
    drive(5'd6, 3'b001, 32'h5678, 1'b0, 7'b0, 32'h104, 32'h0);
    @(negedge clk);
    chk("b2b1_wen", rf_wen, 4'hF);
    chk("b2b1_waddr", rf_waddr, 5'd5);
    chk("b2b1_wdata", rf_wdata, 32'h1234);
    chk("b2b1_en", WB_enable, 1'b1);
    step();
    idle();
    @(negedge clk);
    chk("b2b2_wen", rf_wen, 4'hF);
    chk("b2b2_waddr", rf_waddr, 5'd6);
    chk("b2b2_wdata", rf_wdata, 32'h5678);
    chk("b2b2_en", WB_enable, 1'b1);
    step();

    load_test("lb",  7'b0100000, 32'h1000_0003, 32'h0, 32'h80FF_0000, 3, 32'hFFFF_FF80);
    load_test("lbu", 7'b0010000, 32'h1000_0003, 32'h0, 32'h80FF_0000, 3, 32'h0000_0080);
    load_test("lwl", 7'b0000010, 32'h1000_0001, 32'hAABB_CCDD, 32'h1122_3344, 0, 32'h3344_CCDD);
    load_test("lwr", 7'b0000001, 32'h1000_0002, 32'hAABB_CCDD, 32'h1122_3344, 1, 32'hAABB_1122);
    load_test("lh",  7'b0001000, 32'h1000_0002, 32'h0, 32'h80FF_0000, 0, 32'hFFFF_80FF);
    load_test("lhu", 7'b0000100, 32'h1000_0002, 32'h0, 32'h80FF_0000, 0, 32'h0000_80FF);
    load_test("lw",  7'b1000000, 32'h1000_0000, 32'h0, 32'h80FF_0000, 2, 32'h80FF_0000);

    // link: PC+8
    drive(5'd31, 3'b100, 32'h0, 1'b0, 7'b0, 32'hBFC0_0100, 32'h0);
    step();
    idle();
    @(negedge clk);
    chk("link_wdata", rf_wdata, 32'hBFC0_0108);
    chk("link_waddr", rf_waddr, 5'd31);
    step();

    // reset while a load waits, then late data is a protocol error
    drive(5'd4, 3'b010, 32'h2000_0000, 1'b1, 7'b1000000, 32'h300, 32'h0);
    step();
    idle();
    @(negedge clk);
    chk("rstw_stall", WB_enable, 1'b0);
    rst_p = 1;
    step();
    rst_p = 0;
    @(negedge clk);
    chk("rstw_valid", valid_out, 1'b0);
    chk("rstw_wen", rf_wen, 4'h0);
    mem_rdata_valid = 1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("late_wen", rf_wen, 4'h0);
    step();
    idle();
    @(negedge clk);
    chk("late_perr", protocol_err, 1'b1);
    rst_p = 1;
    step();
    rst_p = 0;
    @(negedge clk);
    chk("perr_cleared", protocol_err, 1'b0);

    // stray data pulse while idle; flag is sticky until reset
    mem_rdata_valid = 1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    chk("stray_wen", rf_wen, 4'h0);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_perr_sticky", protocol_err, 1'b1);
      step();
    end
    rst_p = 1;
    step();
    rst_p = 0;
    @(negedge clk);
    chk("stray_perr_reset", protocol_err, 1'b0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage MIPS pipeline, directly downstream of the memory-access stage. It accepts one instruction per handshake. For loads it waits for the returned memory word and aligns or merges it: lw/lb/lbu/lh/lhu/lwl/lwr. It then selects the write-back source and drives the register-file write port for exactly one cycle per instruction.

## Interface
Parameters:
- none

Ports:
- clk  in  1  clock. One clock; all state updates on its rising edge.
- rst_p  in  1  reset. Synchronous, active-high.
- MA_ready  in  1  upstream stage holds a completed instruction.
- WB_enable  out  1  this stage can accept an instruction this cycle.
- mem_rdata_valid  in  1  memory interlayer returns read data this cycle.
- mem_rdata  in  32  returned word, from a word-aligned address.
- rf_B_in  in  32  old rt value, used by the lwl/lwr merge.
- rf_waddr_in  in  5  destination register.
- rf_wdata_src_in  in  3  one-hot source select: [0] alu_res, [1] load data, [2] PC+8.
- rf_wen_in  in  1  instruction writes the register file.
- alu_res_in  in  32  result, or effective address for loads.
- mem_read_in  in  1  instruction is a load with an outstanding read.
- align_load_in  in  7  one-hot load type: [6] lw, [5] lb, [4] lbu, [3] lh, [2] lhu, [1] lwl, [0] lwr.
- MA_PC  in  32  PC of the incoming instruction.
- rf_wen  out  4  byte write strobes to the register file.
- rf_waddr  out  5  write address.
- rf_wdata  out  32  write data.
- WB_PC  out  32  PC of the instruction currently held.
- valid_out  out  1  stage holds an instruction (used by forwarding).
- protocol_err  out  1  sticky error flag.

## Operation
- **Handshake.** comming = WB_enable && MA_ready; leaving = valid && !(mem_read && !mem_rdata_valid); WB_enable = !valid || leaving.
- **On comming.** Latch all *_in fields and MA_PC; set valid. Otherwise valid clears on leaving.
- **State machine** (2 states, derived from valid and mem_read):
  - IDLE: no instruction held.
  - HOLD: instruction held; if mem_read=1, wait here for mem_rdata_valid.
  - HOLD→IDLE on leaving without comming.
  - HOLD→HOLD on leaving and comming in the same cycle (back-to-back).
- **Load data.** Uses mem_rdata combinationally in the cycle mem_rdata_valid is high; there is no read-data buffer. a = alu_res[1:0].
  - lw: mem_rdata.
  - lb / lbu: byte a, sign- / zero-extended.
  - lh / lhu: halfword a[1], sign- / zero-extended.
  - lwl: a=0 {d[7:0],rt[23:0]}; 1 {d[15:0],rt[15:0]}; 2 {d[23:0],rt[7:0]}; 3 d.
  - lwr: a=0 d; 1 {rt[31:24],d[31:8]}; 2 {rt[31:16],d[31:16]}; 3 {rt[31:8],d[31:24]}.
  - Here d = mem_rdata and rt = rf_B.
- **Write data.** rf_wdata = AND-OR of alu_res, load data and WB_PC+8 by rf_wdata_src.
- **Write strobes.** rf_wen = {4{valid && rf_wen_r && leaving}}.
  - Strobes are always all-ones when asserted: lwl/lwr merging is done in the data, not by partial strobes.
  - rf_waddr=0 is still issued; the register file discards it.
- **protocol_err.** Set when mem_rdata_valid is high while not (valid && mem_read). Cleared only by reset. The stray data is ignored.

## Timing
- **Reset values:**
  - valid=0, rf_wen=0, protocol_err=0, WB_PC=0.
  - All latched fields are 0; rf_waddr and rf_wdata are therefore 0.
  - WB_enable=1.
- **Non-load latency.** Captured at edge N; writes in cycle N+1 and leaves that cycle. Throughput is 1/cycle.
- **Load latency.** Writes in the first cycle with mem_rdata_valid after capture. The memory read is issued when the upstream stage leaves, so the earliest write is cycle N+1.
- **Stall behaviour.** While waiting: WB_enable=0, rf_wen=0, and all held fields are stable.
- **Simultaneous events:**
  - Leaving and comming in one cycle: the write uses the old fields; the new fields load at the edge.
  - Reset has priority over comming.
  - Reset while waiting: drop the instruction, no write, return to IDLE.
- **Combinational paths.** WB_enable depends on mem_rdata_valid. It must not depend on MA_ready, which would form a loop.

## Structure
- **Shared package:**
  - Bit-index constants for align_load (LD_LW..LD_LWR) and rf_wdata_src (SRC_ALU, SRC_MEM, SRC_PC8).
  - The same constants are used by the decode and memory-access stages.
- **Sub-module load_align:** purely combinational. Inputs: mem_rdata, rf_B, addr[1:0], align_load. Output: the 32-bit aligned load result.
- Everything else is flat in wb_stage.

## Test plan
- Back-to-back ALU ops, r5 alu_res=0x1234 then r6 alu_res=0x5678 → rf_wen=4'hF in consecutive cycles with correct waddr/wdata; WB_enable stays 1.
- lb at addr 0x...3, mem_rdata=0x80FF_0000 delivered 3 cycles late → 3 cycles of WB_enable=0 and rf_wen=0, then rf_wdata=0xFFFF_FF80. Same with lbu → 0x0000_0080.
- lwl addr[1:0]=1, rt=0xAABBCCDD, d=0x11223344 → rf_wdata=0x3344CCDD. lwr addr[1:0]=2, same operands → rf_wdata=0xAABB1122.
- Link instruction with PC=0xBFC0_0100, src=PC+8 → rf_wdata=0xBFC0_0108.
- Reset asserted while a load is waiting → next cycle valid_out=0, no write. Data returned afterwards → protocol_err=1.
- mem_rdata_valid pulse in IDLE → protocol_err=1 and no write; it stays 1 until rst_p.
